// File: rtl/pc_ctrl_pkg.sv
// Branch-condition encodings, flag bit layout and redirect classes shared by
// the PC redirect path.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        COND_EQ  = 3'b000,
        COND_NE  = 3'b001,
        COND_LT  = 3'b010,
        COND_GE  = 3'b011,
        COND_LE  = 3'b100,
        COND_GT  = 3'b101,
        COND_AL0 = 3'b110,
        COND_AL1 = 3'b111
    } br_cond_e;

    // flags bus is {Z, V, N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BRANCH = 3'd1,
        RD_CALL   = 3'd2,
        RD_RET    = 3'd3,
        RD_JREG   = 3'd4
    } redir_e;

    function automatic logic cond_taken(input br_cond_e cond, input logic [2:0] flags);
        logic z;
        logic lt;
        logic taken;
        z  = flags[FLAG_Z];
        lt = flags[FLAG_N] ^ flags[FLAG_V];
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_LT: taken = lt;
            COND_GE: taken = !lt;
            COND_LE: taken = z | lt;
            COND_GT: taken = !z & !lt;
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;

    // wp_q always points at the next free slot; the top lives just below it.
    always_comb begin
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        top_idx = wp_q - PTR_W'(1);
        if (push) begin
            wp_d = wp_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            wp_d  = wp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= push_data;
        end
    end

    assign top   = mem_q[top_idx];
    assign count = cnt_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Zero-latency PC redirect arbiter: branch > call > ret > jreg, with a return
// address stack, post-branch blanking and registered hazard-clear pulses.
module pc_redirect_unit
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IMM_W     = 26,
    parameter int RAS_DEPTH = 8,
    parameter int BR_BLANK  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic [2:0]        branch_cond,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [2:0]        flags,
    input  logic              call,
    input  logic              ret,
    input  logic              jreg,
    input  logic              data_hazard,
    input  logic [IMM_W-1:0]  j_type_imm,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] reg_1_data,
    input  logic [ADDR_W-1:0] ret_addr,
    input  logic [ADDR_W-1:0] stack_pc,
    output logic [ADDR_W-1:0] pc_update,
    output logic              pc_src,
    output logic              clr_branch_hazard_ff,
    output logic              clr_call_hazard_ff,
    output logic              clr_ret_hazard_ff,
    output logic              clr_jreg_hazard_ff,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_miss
);

    localparam int BLANK_W = $clog2(BR_BLANK + 1);
    localparam int CNT_W   = $clog2(RAS_DEPTH) + 1;

    redir_e             winner;
    logic               br_acc, call_acc, ret_acc, jreg_acc;
    logic               ras_hit;
    logic [ADDR_W-1:0]  ras_top;
    logic [CNT_W-1:0]   ras_count;

    logic [BLANK_W-1:0] blank_q, blank_d;
    logic               ret_hold_q, ret_hold_d;
    logic               clr_branch_q, clr_branch_d;
    logic               clr_call_q, clr_call_d;
    logic               clr_ret_q, clr_ret_d;
    logic               clr_jreg_q, clr_jreg_d;

    logic               unused_pc_lo;
    assign unused_pc_lo = ^pc_in[IMM_W-1:0];

    // Each class qualifies only if every higher-priority class lost, so at
    // most one acc is ever high and reset masks them all.
    always_comb begin
        br_acc   = !rst && branch && (blank_q == '0);
        call_acc = !rst && call && !data_hazard && !br_acc;
        ret_acc  = !rst && ret && !data_hazard && !br_acc && !call_acc && !ret_hold_q;
        jreg_acc = !rst && jreg && !data_hazard && !br_acc && !call_acc && !ret_acc;

        winner = RD_NONE;
        if (br_acc) begin
            winner = RD_BRANCH;
        end else if (call_acc) begin
            winner = RD_CALL;
        end else if (ret_acc) begin
            winner = RD_RET;
        end else if (jreg_acc) begin
            winner = RD_JREG;
        end

        ras_hit = (ras_count != '0);
    end

    always_comb begin
        pc_update = '0;
        pc_src    = 1'b0;
        ras_miss  = 1'b0;
        case (winner)
            RD_BRANCH: begin
                pc_update = alu_result;
                pc_src    = cond_taken(br_cond_e'(branch_cond), flags);
            end
            RD_CALL: begin
                pc_update = {pc_in[ADDR_W-1:IMM_W], j_type_imm};
                pc_src    = 1'b1;
            end
            RD_RET: begin
                pc_update = ras_hit ? ras_top : stack_pc;
                pc_src    = 1'b1;
                ras_miss  = !ras_hit;
            end
            RD_JREG: begin
                pc_update = reg_1_data;
                pc_src    = 1'b1;
            end
            default: begin
                pc_update = '0;
                pc_src    = 1'b0;
            end
        endcase
    end

    // Holding ret high keeps it blocked until the request drops.
    always_comb begin
        blank_d = blank_q;
        if (br_acc) begin
            blank_d = BLANK_W'(BR_BLANK);
        end else if (blank_q != '0) begin
            blank_d = blank_q - BLANK_W'(1);
        end
        ret_hold_d   = ret_acc || (ret_hold_q && ret);
        clr_branch_d = br_acc;
        clr_call_d   = call_acc;
        clr_ret_d    = ret_acc;
        clr_jreg_d   = jreg_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q      <= '0;
            ret_hold_q   <= 1'b0;
            clr_branch_q <= 1'b0;
            clr_call_q   <= 1'b0;
            clr_ret_q    <= 1'b0;
            clr_jreg_q   <= 1'b0;
        end else begin
            blank_q      <= blank_d;
            ret_hold_q   <= ret_hold_d;
            clr_branch_q <= clr_branch_d;
            clr_call_q   <= clr_call_d;
            clr_ret_q    <= clr_ret_d;
            clr_jreg_q   <= clr_jreg_d;
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (call_acc),
        .pop       (ret_acc && ras_hit),
        .push_data (ret_addr),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign clr_branch_hazard_ff = clr_branch_q;
    assign clr_call_hazard_ff   = clr_call_q;
    assign clr_ret_hazard_ff    = clr_ret_q;
    assign clr_jreg_hazard_ff   = clr_jreg_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: stimulus queues hand-computed
// per-cycle expectations, a monitor pops and compares them at the falling edge.
module tb_pc_redirect_unit;

    localparam int C_NONE = 0;
    localparam int C_BR   = 1;
    localparam int C_CALL = 2;
    localparam int C_RET  = 3;
    localparam int C_JREG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch;
    logic [2:0]  branch_cond;
    logic [31:0] alu_result;
    logic [2:0]  flags;
    logic        call, ret, jreg, data_hazard;
    logic [25:0] j_type_imm;
    logic [31:0] pc_in, reg_1_data, ret_addr, stack_pc;
    logic [31:0] pc_update;
    logic        pc_src;
    logic        clr_branch_hazard_ff, clr_call_hazard_ff, clr_ret_hazard_ff, clr_jreg_hazard_ff;
    logic        ras_empty, ras_full, ras_miss;

    typedef struct {
        string       name;
        logic        src;
        logic [31:0] pc;
        logic        miss;
        logic [3:0]  clr;
        logic [1:0]  ef;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   npass   = 0;
    int   prev_cls = C_NONE;

    logic [2:0] cond_tab [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic       src_tab  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    pc_redirect_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .branch               (branch),
        .branch_cond          (branch_cond),
        .alu_result           (alu_result),
        .flags                (flags),
        .call                 (call),
        .ret                  (ret),
        .jreg                 (jreg),
        .data_hazard          (data_hazard),
        .j_type_imm           (j_type_imm),
        .pc_in                (pc_in),
        .reg_1_data           (reg_1_data),
        .ret_addr             (ret_addr),
        .stack_pc             (stack_pc),
        .pc_update            (pc_update),
        .pc_src               (pc_src),
        .clr_branch_hazard_ff (clr_branch_hazard_ff),
        .clr_call_hazard_ff   (clr_call_hazard_ff),
        .clr_ret_hazard_ff    (clr_ret_hazard_ff),
        .clr_jreg_hazard_ff   (clr_jreg_hazard_ff),
        .ras_empty            (ras_empty),
        .ras_full             (ras_full),
        .ras_miss             (ras_miss)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] exv);
        nchecks++;
        if (act === exv) begin
            npass++;
        end else begin
            $display("FAIL %s.%s got 0x%0h expected 0x%0h", nm, field, act, exv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "pc_src", 32'(pc_src), 32'(e.src));
                cmp(e.name, "pc_update", pc_update, e.pc);
                cmp(e.name, "ras_miss", 32'(ras_miss), 32'(e.miss));
                cmp(e.name, "clr_bcrj", 32'({clr_branch_hazard_ff, clr_call_hazard_ff,
                                             clr_ret_hazard_ff, clr_jreg_hazard_ff}), 32'(e.clr));
                cmp(e.name, "empty_full", 32'({ras_empty, ras_full}), 32'(e.ef));
            end
        end
    end

    // cnt is the RAS occupancy held in the registers during this cycle.
    task automatic chk(input string nm, input int cls, input logic src, input logic [31:0] pc,
                       input logic miss, input int cnt);
        exp_t e;
        e.name = nm;
        e.src  = src;
        e.pc   = pc;
        e.miss = miss;
        e.clr  = {prev_cls == C_BR, prev_cls == C_CALL, prev_cls == C_RET, prev_cls == C_JREG};
        e.ef   = {cnt == 0, cnt == 8};
        exp_q.push_back(e);
        prev_cls = cls;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        branch = 0; branch_cond = 0; alu_result = 0; flags = 0;
        call = 0; ret = 0; jreg = 0; data_hazard = 0;
        j_type_imm = 0; pc_in = 0; reg_1_data = 0; ret_addr = 0; stack_pc = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;

        // request during reset is ignored, nothing pushed
        call = 1; ret_addr = 32'hAA;
        chk("rst_ignore", C_NONE, 0, 0, 0, 0);
        rst = 0; idle_inputs();
        chk("idle", C_NONE, 0, 0, 0, 0);

        // EQ with Z=1, branch held three cycles
        flags = 3'b100; branch_cond = 3'b000; alu_result = 32'h40; branch = 1;
        chk("br_eq_c0", C_BR, 1, 32'h40, 0, 0);
        chk("br_eq_c1", C_NONE, 0, 0, 0, 0);
        chk("br_eq_c2", C_NONE, 0, 0, 0, 0);
        branch = 0;

        // N=1, V=0: LT GE LE GT AL
        flags = 3'b001; alu_result = 32'h80;
        for (int i = 0; i < 5; i++) begin
            branch = 1; branch_cond = cond_tab[i];
            chk($sformatf("br_cond%0d", cond_tab[i]), C_BR, src_tab[i], 32'h80, 0, 0);
            branch = 0;
            chk("br_gap0", C_NONE, 0, 0, 0, 0);
            chk("br_gap1", C_NONE, 0, 0, 0, 0);
        end
        idle_inputs();

        // call target splice and single push/pop
        pc_in = 32'hFC00_0010; j_type_imm = 26'h123; ret_addr = 32'h11; call = 1;
        chk("call", C_CALL, 1, 32'hFC00_0123, 0, 0);
        idle_inputs();
        chk("call_after", C_NONE, 0, 0, 0, 1);
        ret = 1;
        chk("ret", C_RET, 1, 32'h11, 0, 1);
        ret = 0;
        chk("ret_after", C_NONE, 0, 0, 0, 0);

        // 9 pushes into an 8-deep stack
        for (int i = 1; i <= 9; i++) begin
            call = 1; pc_in = 0; j_type_imm = 26'(i); ret_addr = 32'(i);
            chk($sformatf("fill%0d", i), C_CALL, 1, 32'(i), 0, (i - 1 > 8) ? 8 : i - 1);
        end
        idle_inputs();
        chk("full", C_NONE, 0, 0, 0, 8);
        stack_pc = 32'hDEAD_0000;
        for (int k = 0; k < 8; k++) begin
            ret = 1;
            chk($sformatf("pop%0d", k), C_RET, 1, 32'(9 - k), 0, 8 - k);
            ret = 0;
            chk("pop_gap", C_NONE, 0, 0, 0, 7 - k);
        end
        ret = 1;
        chk("pop_miss", C_RET, 1, 32'hDEAD_0000, 1, 0);
        chk("ret_held", C_NONE, 0, 0, 0, 0);
        idle_inputs();
        chk("ret_drop", C_NONE, 0, 0, 0, 0);

        // priority: branch beats call and jreg, no push
        branch = 1; branch_cond = 3'b110; alu_result = 32'h200;
        call = 1; ret_addr = 32'h55; jreg = 1; reg_1_data = 32'h300;
        chk("prio_br", C_BR, 1, 32'h200, 0, 0);
        idle_inputs();
        chk("prio_after", C_NONE, 0, 0, 0, 0);
        chk("prio_gap", C_NONE, 0, 0, 0, 0);

        // data hazard blocks call
        call = 1; data_hazard = 1; ret_addr = 32'h66;
        chk("hazard_call", C_NONE, 0, 0, 0, 0);
        idle_inputs();
        chk("hazard_after", C_NONE, 0, 0, 0, 0);

        jreg = 1; reg_1_data = 32'h300;
        chk("jreg", C_JREG, 1, 32'h300, 0, 0);
        idle_inputs();
        chk("jreg_after", C_NONE, 0, 0, 0, 0);

        // three pushes, then reset discards them
        for (int i = 0; i < 3; i++) begin
            call = 1; j_type_imm = 26'h10; ret_addr = 32'hA1 + 32'(i);
            chk($sformatf("chain%0d", i), C_CALL, 1, 32'h10, 0, i);
        end
        idle_inputs();
        rst = 1; ret = 1; stack_pc = 32'hBEEF_0000;
        chk("rst_mid", C_NONE, 0, 0, 0, 3);
        rst = 0;
        chk("ret_after_rst", C_RET, 1, 32'hBEEF_0000, 1, 0);
        idle_inputs();
        chk("end_idle", C_NONE, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            nchecks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
